// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB requester (apb_master) and the APB memory
// slave (apb_mem) that sit on the same bus.
//   apb_state_t     : requester transfer phase (IDLE / SETUP / ACCESS)
//   APB_ADDR_WIDTH  : default APB address width
//   APB_DATA_WIDTH  : default APB data width
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 10;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

endpackage : apb_pkg

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// APB requester: turns a valid/ready command into one APB SETUP + ACCESS
// transfer and reports completion with a single-cycle response pulse.
//
// Optional build macro: APB_MASTER_TIMEOUT_EN
//   When defined, an ACCESS phase stalled by pready=0 is aborted once the
//   wait counter reaches TIMEOUT_CYCLES; the response then carries rsp_err=1
//   and rsp_rdata=0. When undefined, ACCESS waits indefinitely and rsp_err
//   is always 0.
//
// Ports
//   pclk       in   APB clock, rising edge
//   PRESET     in   asynchronous active-high reset
//   cmd_valid  in   command request
//   cmd_ready  out  command accepted on cmd_valid && cmd_ready
//   cmd_write  in   1 = write, 0 = read
//   cmd_addr   in   transfer address
//   cmd_wdata  in   write data (ignored for reads)
//   rsp_valid  out  one-cycle completion pulse
//   rsp_rdata  out  read data (0 for writes and aborts)
//   rsp_err    out  transfer aborted by timeout
//   paddr/pwrite/psel/penable/pwdata  out  APB requester signals
//   prdata/pready                     in   APB completer signals
// ---------------------------------------------------------------------------
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  PRESET,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response side
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB bus
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_t state, state_nxt;
  logic       accept;     // command handshake this cycle
  logic       complete;   // current ACCESS ends at this edge (normal or abort)
  logic       timed_out;  // ACCESS ends at this edge by abort

  // -------------------------------------------------------------------------
  // Timeout counter
  // -------------------------------------------------------------------------
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // pready=1 on the terminal count is a normal completion, so the abort
  // condition requires pready=0.
  assign timed_out = (state == APB_ACCESS) && !pready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge pclk or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (state == APB_SETUP) begin
      // ACCESS is only ever entered from SETUP, so clearing here clears on entry.
      wait_cnt <= '0;
    end else if (state == APB_ACCESS && !pready && !timed_out) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  assign complete = (state == APB_ACCESS) && (pready || timed_out);
  assign accept   = cmd_valid && cmd_ready;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  // NOTE: state and every other register below use non-blocking assignments so
  // all flops update together from pre-edge values, independent of block order.
  always_ff @(posedge pclk or posedge PRESET) begin
    if (PRESET) state <= APB_IDLE;
    else        state <= state_nxt;
  end

  // psel/penable decode straight from the state register, so the asynchronous
  // reset drops them immediately rather than at the next edge.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_nxt = state;
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;

    unique case (state)
      APB_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = APB_SETUP;
      end
      APB_SETUP: begin
        psel      = 1'b1;
        state_nxt = APB_ACCESS;
      end
      APB_ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        // Ready combinationally with completion to allow back-to-back issue.
        cmd_ready = complete;
        if (complete) state_nxt = cmd_valid ? APB_SETUP : APB_IDLE;
      end
      default: state_nxt = APB_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Command registers: APB address/direction/data only move on accept, so they
  // stay stable through wait states and hold their value while idle.
  // -------------------------------------------------------------------------
  always_ff @(posedge pclk or posedge PRESET) begin
    if (PRESET) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
    end else if (accept) begin
      paddr  <= cmd_addr;
      pwrite <= cmd_write;
      pwdata <= cmd_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Response: registered at the completion edge, high for exactly one cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge pclk or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= complete;
      rsp_err   <= timed_out;
      rsp_rdata <= (complete && pready && !pwrite) ? prdata : '0;
    end
  end

endmodule : apb_master

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
// Self-checking bench for apb_master. A behavioural APB memory slave with a
// programmable wait-state count answers the bus; a reference memory array
// predicts read data and the expected cycle-by-cycle bus phases are derived
// from the transfer timing rules (SETUP one cycle after accept, ACCESS for
// 1 + wait cycles, response the cycle after completion).
// Build with +define+APB_MASTER_TIMEOUT_EN to also exercise the timeout.
// ---------------------------------------------------------------------------
module tb_apb_master;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] ref_mem [1<<AW];  // expected memory contents
  logic [DW-1:0] slv_mem [1<<AW];  // slave storage
  int            wait_states = 0;
  bit            stuck = 1'b0;
  int            acc_cnt;

  always #5 pclk = ~pclk;

  apb_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk     (pclk),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .paddr    (paddr),
    .pwrite   (pwrite),
    .psel     (psel),
    .penable  (penable),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready)
  );

  // Behavioural APB memory slave
  assign prdata = slv_mem[paddr];
  assign pready = psel && penable && !stuck && (acc_cnt >= wait_states);

  always @(posedge pclk or posedge PRESET) begin
    if (PRESET)                            acc_cnt <= 0;
    else if (psel && penable && !pready)   acc_cnt <= acc_cnt + 1;
    else                                   acc_cnt <= 0;
  end

  always @(posedge pclk) begin
    if (!PRESET && psel && penable && pready && pwrite) slv_mem[paddr] <= pwdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One complete transfer, entered and left at a negedge with the DUT idle.
  // waits = number of ACCESS cycles with pready=0; expect_to = abort expected.
  task automatic run_xfer(input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int waits,
                          input bit expect_to);
    logic [DW-1:0] exp_rd;
    int            rsp_c;
    rsp_c  = 3 + waits;
    exp_rd = (wr || expect_to) ? '0 : ref_mem[a];
    if (wr && !expect_to) ref_mem[a] = d;
    wait_states = waits;
    stuck       = expect_to;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_ready: got %b want 1", cmd_ready);
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
    for (int c = 1; c <= rsp_c + 1; c++) begin
      @(negedge pclk);
      if (c == 1) begin
        n_cmp++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b1000) begin
          n_bad++;
          $display("FAIL setup_phase: psel/penable/rsp_valid/cmd_ready got %b want 1000",
                   {psel, penable, rsp_valid, cmd_ready});
        end
      end else if (c < rsp_c) begin
        n_cmp++;
        if ({psel, penable, rsp_valid, cmd_ready} !== {3'b110, (c == rsp_c - 1)}) begin
          n_bad++;
          $display("FAIL access_phase c=%0d: psel/penable/rsp_valid/cmd_ready got %b want %b",
                   c, {psel, penable, rsp_valid, cmd_ready}, {3'b110, (c == rsp_c - 1)});
        end
        n_cmp++;
        if ({paddr, pwrite, pwdata} !== {a, wr, d}) begin
          n_bad++;
          $display("FAIL bus_hold c=%0d: addr/write/wdata got %h/%b/%h want %h/%b/%h",
                   c, paddr, pwrite, pwdata, a, wr, d);
        end
      end else if (c == rsp_c) begin
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, expect_to, exp_rd}) begin
          n_bad++;
          $display("FAIL response: valid/err/rdata got %b/%b/%h want 1/%b/%h",
                   rsp_valid, rsp_err, rsp_rdata, expect_to, exp_rd);
        end
        n_cmp++;
        if ({psel, penable, cmd_ready} !== 3'b001) begin
          n_bad++;
          $display("FAIL back_to_idle: psel/penable/cmd_ready got %b want 001",
                   {psel, penable, cmd_ready});
        end
      end else begin
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL rsp_pulse_width: rsp_valid got %b want 0", rsp_valid);
        end
      end
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    n_cmp++;
    if ({paddr, pwrite, psel, penable, pwdata, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: addr=%h wr=%b sel=%b en=%b wdata=%h rv=%b rd=%h err=%b want all 0",
               paddr, pwrite, psel, penable, pwdata, rsp_valid, rsp_rdata, rsp_err);
    end
    PRESET = 1'b0;
    @(negedge pclk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write_read();
    run_xfer(1'b1, 10'd5, 32'hABCD1234, 0, 1'b0);
    n_cmp++;
    if (slv_mem[5] !== 32'hABCD1234) begin
      n_bad++;
      $display("FAIL mem_readback: got %h want abcd1234", slv_mem[5]);
    end
    run_xfer(1'b0, 10'd5, $urandom, 0, 1'b0);
  endtask

  task automatic test_wait_states();
    run_xfer(1'b0, 10'd5, $urandom, 3, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_xfer(1'($urandom), AW'($urandom_range(0, 15)), $urandom,
               int'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd_junk;
    bit [7:0]      obs [6];
    bit [7:0]      exp [6];
    rd_junk = $urandom;
    wait_states = 0;
    ref_mem[16] = 32'h11111111;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h10; cmd_wdata = 32'h11111111;
    @(posedge pclk); #1;
    cmd_write = 1'b0; cmd_wdata = rd_junk;          // read stays pending
    @(negedge pclk); obs[0] = {psel, penable, cmd_ready, rsp_valid, pwrite, 3'b0};
    @(negedge pclk); obs[1] = {psel, penable, cmd_ready, rsp_valid, pwrite, 3'b0};
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    @(negedge pclk); obs[2] = {psel, penable, cmd_ready, rsp_valid, pwrite, 3'b0};
    n_cmp++;
    if ({rsp_err, rsp_rdata, paddr, pwdata} !== {1'b0, 32'h0, 10'h10, rd_junk}) begin
      n_bad++;
      $display("FAIL b2b_write_rsp: err/rdata/addr/wdata got %b/%h/%h/%h want 0/0/010/%h",
               rsp_err, rsp_rdata, paddr, pwdata, rd_junk);
    end
    @(negedge pclk); obs[3] = {psel, penable, cmd_ready, rsp_valid, pwrite, 3'b0};
    @(negedge pclk); obs[4] = {psel, penable, cmd_ready, rsp_valid, pwrite, 3'b0};
    n_cmp++;
    if ({rsp_err, rsp_rdata} !== {1'b0, 32'h11111111}) begin
      n_bad++;
      $display("FAIL b2b_read_rsp: err/rdata got %b/%h want 0/11111111", rsp_err, rsp_rdata);
    end
    @(negedge pclk); obs[5] = {psel, penable, cmd_ready, rsp_valid, pwrite, 3'b0};
    // {psel, penable, cmd_ready, rsp_valid, pwrite}
    exp[0] = 8'b10001_000;  // write SETUP
    exp[1] = 8'b11101_000;  // write ACCESS, completes, read accepted
    exp[2] = 8'b10010_000;  // read SETUP, write response
    exp[3] = 8'b11100_000;  // read ACCESS
    exp[4] = 8'b00110_000;  // idle, read response
    exp[5] = 8'b00100_000;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (obs[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL b2b_phase cycle=%0d: sel/en/ready/rv/wr got %b want %b",
                 i + 1, obs[i][7:3], exp[i][7:3]);
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_states = 5;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h20; cmd_wdata = 32'hDEAD_BEEF;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    n_cmp++;
    if ({psel, penable} !== 2'b11) begin
      n_bad++;
      $display("FAIL pre_reset_access: psel/penable got %b want 11", {psel, penable});
    end
    #2 PRESET = 1'b1;
    #1;
    n_cmp++;
    if ({psel, penable} !== 2'b00) begin
      n_bad++;
      $display("FAIL async_reset_drop: psel/penable got %b want 00", {psel, penable});
    end
    @(negedge pclk);
    PRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      n_cmp++;
      if ({rsp_valid, psel} !== 2'b00) begin
        n_bad++;
        $display("FAIL no_rsp_after_reset: rsp_valid/psel got %b want 00", {rsp_valid, psel});
      end
    end
    // Lost write: address 0x20 still holds its old contents.
    run_xfer(1'b0, 10'h20, $urandom, 0, 1'b0);
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    run_xfer(1'b0, 10'd7, $urandom, TO, 1'b1);
    run_xfer(1'b1, 10'd8, 32'h5555AAAA, TO, 1'b1);
    run_xfer(1'b0, 10'd8, $urandom, TO - 1, 1'b0);
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    test_reset();
    test_write_read();
    test_wait_states();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_apb_master
